regfile_param: RTL and testbench



---
 rtl/regfile_param_if.sv | 30 +++
 rtl/regfile_param.sv | 142 ++++++++++++++
 tb/tb_regfile_param.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// regfile_param_if
//   Bus between the pipeline and the register file.
//   Parameters: DATA_W (register width), ADDR_W (address width).
//   master : decode/writeback side. It drives the read addresses regA and regB,
//            the write address regD, data_to_w and RegWriteEn. It receives
//            regA_data, regB_data and ready.
//   slave  : register-file side, with the opposite directions.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] regA;
  logic [ADDR_W-1:0] regB;
  logic [ADDR_W-1:0] regD;
  logic [DATA_W-1:0] data_to_w;
  logic              RegWriteEn;
  logic [DATA_W-1:0] regA_data;
  logic [DATA_W-1:0] regB_data;
  logic              ready;

  modport master (
    output regA, regB, regD, data_to_w, RegWriteEn,
    input  regA_data, regB_data, ready
  );

  modport slave (
    input  regA, regB, regD, data_to_w, RegWriteEn,
    output regA_data, regB_data, ready
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param
//   General-purpose register file. It has two combinational read ports and one
//   synchronous write port. Register 0 always reads as zero.
//   After every reset a sequencer loads entry i with i*INIT_STEP. It loads one
//   entry per clock edge, then raises ready.
//   Ports:
//     clk  : sole clock, rising edge.
//     rst  : synchronous, active-high reset.
//     bus  : regfile_param_if.slave, which carries:
//              regA, regB        read addresses
//              regD              write address
//              data_to_w         write data
//              RegWriteEn        write enable
//              regA_data,
//              regB_data         read data
//              ready             initialisation done
//   Build option:
//     REGFILE_BYPASS_EN : when defined, a write in RUN is forwarded in the same
//                         cycle to a read port that addresses regD.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | loading the init pattern; writes ignored, reads return 0
//   ST_RUN  | normal operation; ready = 1
module regfile_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int INIT_STEP = 10
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] STEP     = DATA_W'(INIT_STEP);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // Next state and the single write port. The sequencer and the pipeline share
  // the write port. They never write in the same state, so no arbitration is
  // needed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    // The product is truncated to DATA_W, which gives the required modulo.
    mem_wdata = DATA_W'(cnt_q) * STEP;

    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        // cnt holds at the last index instead of wrapping.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.RegWriteEn && (bus.regD != '0)) begin
          mem_we    = 1'b1;
          mem_waddr = bus.regD;
          mem_wdata = bus.data_to_w;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // The array has no reset. A reset edge discards any write presented on it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports. Address 0 is masked here rather than relying on the array
  // contents. That way entry 0 never has to be protected on the write side
  // during init.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (state_q == ST_RUN) begin
      if (bus.regA != '0) begin
        rd_a = mem_q[bus.regA];
      end
      if (bus.regB != '0) begin
        rd_b = mem_q[bus.regB];
      end
`ifdef REGFILE_BYPASS_EN
      if (bus.RegWriteEn && (bus.regD != '0)) begin
        if (bus.regA == bus.regD) begin
          rd_a = bus.data_to_w;
        end
        if (bus.regB == bus.regD) begin
          rd_b = bus.data_to_w;
        end
      end
`endif
    end
  end

  assign bus.regA_data = rd_a;
  assign bus.regB_data = rd_b;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//   Self-checking bench for regfile_param (default parameters).
//   The reference model keeps a plain array plus a count of edges since reset.
//   Once DEPTH edges have passed, every entry takes i*STEP at once.
//   Honours REGFILE_BYPASS_EN for same-cycle forwarding expectations.
module tb_regfile_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int STEP   = 10;

  logic clk;
  logic rst;

  regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_param #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_STEP(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_since_rst = 0;
  bit                m_ready = 1'b0;
  bit                m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid     = 1'b1;
      m_ready     = 1'b0;
      m_since_rst = 0;
    end else if (m_valid) begin
      if (!m_ready) begin
        m_since_rst++;
        if (m_since_rst == DEPTH) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'(i * STEP);
          m_ready = 1'b1;
        end
      end else if (bus.RegWriteEn && bus.regD != 0) begin
        m_mem[bus.regD] = bus.data_to_w;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!m_ready || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWriteEn && bus.regD != 0 && bus.regD == a) return bus.data_to_w;
`endif
    return m_mem[a];
  endfunction

  // Compare process: inputs change at posedge+1, so check on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready", {31'b0, bus.ready}, {31'b0, m_ready});
      chk("rdA", bus.regA_data, exp_rd(bus.regA));
      chk("rdB", bus.regB_data, exp_rd(bus.regB));
    end
  end

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  int n_edges;

  initial begin
    rst            = 1'b1;
    bus.regA       = '0;
    bus.regB       = '0;
    bus.regD       = '0;
    bus.data_to_w  = '0;
    bus.RegWriteEn = 1'b0;

    // Reset, then init with writes attempted throughout.
    edge_step();
    chk("ready_after_rst", {31'b0, bus.ready}, 32'd0);
    rst            = 1'b0;
    bus.RegWriteEn = 1'b1;
    bus.regD       = 5'd3;
    bus.data_to_w  = 32'h1234;
    bus.regA       = 5'd3;
    bus.regB       = 5'd5;
    #1;
    chk("init_rdA_zero", bus.regA_data, 32'h0);
    wait_ready(n_edges);
    bus.RegWriteEn = 1'b0;
    chk("init_len", n_edges, 32'd32);

    // Init pattern literals.
    bus.regA = 5'd5; bus.regB = 5'd31; #1;
    chk("init_r5", bus.regA_data, 32'd50);
    chk("init_r31", bus.regB_data, 32'd310);
    bus.regA = 5'd0; bus.regB = 5'd3; #1;
    chk("init_r0", bus.regA_data, 32'd0);
    chk("init_write_dropped", bus.regB_data, 32'd30);

    // Write then read.
    bus.regD = 5'd7; bus.data_to_w = 32'hDEADBEEF; bus.RegWriteEn = 1'b1;
    bus.regA = 5'd7; bus.regB = 5'd8;
    edge_step();
    bus.RegWriteEn = 1'b0; #1;
    chk("wr_r7", bus.regA_data, 32'hDEADBEEF);
    chk("wr_r8", bus.regB_data, 32'd80);

    // Register-0 protection.
    bus.regD = 5'd0; bus.data_to_w = 32'hFFFFFFFF; bus.RegWriteEn = 1'b1;
    edge_step();
    bus.RegWriteEn = 1'b0; bus.regA = 5'd0; #1;
    chk("r0_protect", bus.regA_data, 32'd0);

    // Same-cycle write and read.
    bus.regD = 5'd12; bus.regA = 5'd12; bus.data_to_w = 32'h55; bus.RegWriteEn = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_r12", bus.regA_data, 32'h55);
`else
    chk("same_cycle_r12", bus.regA_data, 32'd120);
`endif
    edge_step();
    bus.RegWriteEn = 1'b0; #1;
    chk("after_edge_r12", bus.regA_data, 32'h55);

    // Reset in the middle of RUN.
    bus.regD = 5'd9; bus.data_to_w = 32'hAAAA; bus.RegWriteEn = 1'b1;
    edge_step();
    bus.RegWriteEn = 1'b0; bus.regA = 5'd9; #1;
    chk("r9_written", bus.regA_data, 32'hAAAA);
    rst = 1'b1;
    bus.RegWriteEn = 1'b1; bus.regD = 5'd4; bus.data_to_w = 32'h7777;
    edge_step();
    chk("ready_drop", {31'b0, bus.ready}, 32'd0);
    rst = 1'b0; bus.RegWriteEn = 1'b0;
    wait_ready(n_edges);
    chk("reinit_len", n_edges, 32'd32);
    bus.regA = 5'd9; bus.regB = 5'd7; #1;
    chk("reinit_r9", bus.regA_data, 32'd90);
    chk("reinit_r7", bus.regB_data, 32'd70);
    bus.regA = 5'd4; #1;
    chk("reinit_r4", bus.regA_data, 32'd40);

    // Randomised traffic with occasional resets; the compare process checks it.
    for (int c = 0; c < 3000; c++) begin
      edge_step();
      rst            = ($urandom_range(0, 299) == 0);
      bus.regA       = 5'($urandom);
      bus.regB       = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       bus.regD = bus.regA;
        1:       bus.regD = bus.regB;
        2:       bus.regD = 5'($urandom_range(0, 1));
        default: bus.regD = 5'($urandom);
      endcase
      bus.data_to_w  = $urandom;
      bus.RegWriteEn = 1'($urandom_range(0, 1));
    end
    edge_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
